// File: rtl/traffic_pkg.sv
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types for the intersection controller: light codes
//                and the per-street detector state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    // Light codes, shared with the downstream light FSM.
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        PRESENT = 2'd2,
        HOLD    = 2'd3
    } det_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/car_detect_if.sv
// ============================================================================
//  Module      : car_detect_if
//  Description : Sensor-in / presence-out bundle between the loop sensors and
//                the light FSM. Count signals exist only with CAR_COUNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface car_detect_if
`ifdef CAR_COUNT_EN
    #(parameter int CNT_W = 8)
`endif
;
    logic senseA_raw;
    logic senseB_raw;
    logic carA;
    logic carB;
`ifdef CAR_COUNT_EN
    logic [CNT_W-1:0] countA;
    logic [CNT_W-1:0] countB;
`endif

    modport master (
        output senseA_raw,
        output senseB_raw,
        input  carA,
        input  carB
`ifdef CAR_COUNT_EN
        ,
        input  countA,
        input  countB
`endif
    );

    modport slave (
        input  senseA_raw,
        input  senseB_raw,
        output carA,
        output carB
`ifdef CAR_COUNT_EN
        ,
        output countA,
        output countB
`endif
    );

endinterface

`default_nettype wire

// File: rtl/car_detect_ch.sv
// ============================================================================
//  Module      : car_detect_ch
//  Description : One street channel: 2-flop synchroniser, debounce/hold FSM,
//                shared timer and (with CAR_COUNT_EN) saturating car counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module car_detect_ch
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
`ifdef CAR_COUNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             sense_raw,
    output logic                  car
`ifdef CAR_COUNT_EN
    ,
    output logic [CNT_W-1:0]      count
`endif
);

    localparam int TMR_W = $clog2(max_int(DEB_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    logic             sync_meta;
    logic             sync_s;
    det_state_t       state;
    det_state_t       state_next;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_next;
    logic             new_car;
    logic             car_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= sense_raw;
            sync_s    <= sync_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            car   <= 1'b0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
            car   <= car_next;
        end
    end

    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        new_car    = 1'b0;
        case (state)
            IDLE: begin
                if (sync_s) begin
                    state_next = QUAL;
                    tmr_next   = TMR_ONE;
                end else begin
                    tmr_next   = '0;
                end
            end
            QUAL: begin
                if (!sync_s) begin
                    state_next = IDLE;
                    tmr_next   = '0;
                end else if (tmr == DEB_LAST) begin
                    state_next = PRESENT;
                    tmr_next   = '0;
                    new_car    = 1'b1;
                end else begin
                    tmr_next   = tmr + TMR_ONE;
                end
            end
            PRESENT: begin
                if (!sync_s) begin
                    state_next = HOLD;
                    tmr_next   = TMR_ONE;
                end else begin
                    tmr_next   = '0;
                end
            end
            HOLD: begin
                // Sensor back before expiry means the same vehicle: skip qualification.
                // Expiry fires as the timer would reach HOLD_CYCLES, so car falls
                // HOLD_CYCLES+2 edges after the sensor drops.
                if (sync_s) begin
                    state_next = PRESENT;
                    tmr_next   = '0;
                end else if (tmr >= HOLD_LAST) begin
                    state_next = IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next   = tmr + TMR_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                tmr_next   = '0;
            end
        endcase
        car_next = (state_next == PRESENT) || (state_next == HOLD);
    end

`ifdef CAR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (new_car && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/car_detect.sv
// ============================================================================
//  Module      : car_detect
//  Description : Vehicle-loop front end; two independent car_detect_ch
//                channels producing carA/carB. Optional feature macro:
//                CAR_COUNT_EN (adds countA/countB vehicle counters).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module car_detect
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
`ifdef CAR_COUNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  wire logic   clk,
    input  wire logic   rst,
    car_detect_if.slave bus
);

    car_detect_ch #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
`ifdef CAR_COUNT_EN
        ,
        .CNT_W       (CNT_W)
`endif
    ) u_ch_a (
        .clk       (clk),
        .rst       (rst),
        .sense_raw (bus.senseA_raw),
        .car       (bus.carA)
`ifdef CAR_COUNT_EN
        ,
        .count     (bus.countA)
`endif
    );

    car_detect_ch #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
`ifdef CAR_COUNT_EN
        ,
        .CNT_W       (CNT_W)
`endif
    ) u_ch_b (
        .clk       (clk),
        .rst       (rst),
        .sense_raw (bus.senseB_raw),
        .car       (bus.carB)
`ifdef CAR_COUNT_EN
        ,
        .count     (bus.countB)
`endif
    );

endmodule

`default_nettype wire

// File: tb/tb_car_detect.sv
// ============================================================================
//  Module      : tb_car_detect
//  Description : Scoreboard bench for car_detect; expected carA/carB edges are
//                queued with their edge number, a monitor matches each edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_car_detect;

    typedef struct packed {
        logic        val;
        int unsigned cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    ev_t         qa[$];
    ev_t         qb[$];
    logic        prev_a = 1'b0;
    logic        prev_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef CAR_COUNT_EN
    car_detect_if #(.CNT_W(8)) bus ();
    car_detect_if #(.CNT_W(2)) bus2 ();
    car_detect #(.DEB_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(8)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave));
    car_detect #(.DEB_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave));
    assign bus2.senseA_raw = bus.senseA_raw;
    assign bus2.senseB_raw = bus.senseB_raw;
`else
    car_detect_if bus ();
    car_detect #(.DEB_CYCLES(4), .HOLD_CYCLES(8)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave));
`endif

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ev(input string nm, input bit have, input ev_t e, input logic v);
        n_checks++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: unexpected edge to %0b at edge %0d", nm, v, cyc);
        end else if (e.val !== v || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: got %0b at edge %0d expected %0b at edge %0d",
                     nm, v, cyc, e.val, e.cyc);
        end
    endtask

    // Monitor: every observed edge on carA/carB must match the queue head.
    always @(negedge clk) begin
        ev_t e;
        bit  have;
        if (bus.carA !== prev_a) begin
            have = (qa.size() > 0);
            e    = have ? qa.pop_front() : '0;
            chk_ev("carA_edge", have, e, bus.carA);
            prev_a = bus.carA;
        end
        if (bus.carB !== prev_b) begin
            have = (qb.size() > 0);
            e    = have ? qb.pop_front() : '0;
            chk_ev("carB_edge", have, e, bus.carB);
            prev_b = bus.carB;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic v, input int unsigned c);
        qa.push_back('{val: v, cyc: c});
    endtask

    task automatic push_b(input logic v, input int unsigned c);
        qb.push_back('{val: v, cyc: c});
    endtask

    // One complete vehicle on A: rise DEB+2 edges after raise, fall HOLD+2 after drop.
    task automatic car_a();
        bus.senseA_raw = 1'b1;
        push_a(1'b1, cyc + 6);
        tick(10);
        bus.senseA_raw = 1'b0;
        push_a(1'b0, cyc + 10);
        tick(14);
    endtask

    initial begin
        bus.senseA_raw = 1'b0;
        bus.senseB_raw = 1'b0;
        tick(3);
        check("reset_carA", int'(bus.carA), 0);
        check("reset_carB", int'(bus.carB), 0);
`ifdef CAR_COUNT_EN
        check("reset_countA", int'(bus.countA), 0);
        check("reset_countB", int'(bus.countB), 0);
`endif
        rst = 1'b0;
        tick(2);

        // Short pulse: three high samples never qualify.
        bus.senseA_raw = 1'b1;
        tick(3);
        bus.senseA_raw = 1'b0;
        tick(12);
        check("short_pulse_carA", int'(bus.carA), 0);
`ifdef CAR_COUNT_EN
        check("short_pulse_countA", int'(bus.countA), 0);
`endif

        // Held high: carA rises after edge 6.
        bus.senseA_raw = 1'b1;
        push_a(1'b1, cyc + 6);
        tick(12);
        check("held_carA", int'(bus.carA), 1);
`ifdef CAR_COUNT_EN
        check("held_countA", int'(bus.countA), 1);
`endif

        // Five-cycle gap: same vehicle, no edge, no count.
        bus.senseA_raw = 1'b0;
        tick(5);
        bus.senseA_raw = 1'b1;
        tick(10);
        check("gap_carA", int'(bus.carA), 1);
`ifdef CAR_COUNT_EN
        check("gap_countA", int'(bus.countA), 1);
`endif

        // Drop: carA falls after edge k+10; then a second vehicle.
        bus.senseA_raw = 1'b0;
        push_a(1'b0, cyc + 10);
        tick(14);
        car_a();
`ifdef CAR_COUNT_EN
        check("second_countA", int'(bus.countA), 2);
`endif

        // Simultaneous rise/fall on both streets.
        bus.senseA_raw = 1'b1;
        bus.senseB_raw = 1'b1;
        push_a(1'b1, cyc + 6);
        push_b(1'b1, cyc + 6);
        tick(10);
        bus.senseA_raw = 1'b0;
        bus.senseB_raw = 1'b0;
        push_a(1'b0, cyc + 10);
        push_b(1'b0, cyc + 10);
        tick(14);
`ifdef CAR_COUNT_EN
        check("both_countA", int'(bus.countA), 3);
        check("both_countB", int'(bus.countB), 1);
`endif

        // Three more vehicles: six in total, 2-bit counter saturates at 3.
        for (int i = 0; i < 3; i++) car_a();
`ifdef CAR_COUNT_EN
        check("six_countA", int'(bus.countA), 6);
        check("sat_countA_w2", int'(bus2.countA), 3);
        check("sat_countB_w2", int'(bus2.countB), 1);
`endif

        // Reset mid-PRESENT: both cars drop before the next clock edge.
        bus.senseA_raw = 1'b1;
        bus.senseB_raw = 1'b1;
        push_a(1'b1, cyc + 6);
        push_b(1'b1, cyc + 6);
        tick(10);
        check("pre_rst_carA", int'(bus.carA), 1);
        check("pre_rst_carB", int'(bus.carB), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_a(1'b0, cyc);
        push_b(1'b0, cyc);
        #1;
        check("async_rst_carA", int'(bus.carA), 0);
        check("async_rst_carB", int'(bus.carB), 0);
`ifdef CAR_COUNT_EN
        check("async_rst_countA", int'(bus.countA), 0);
        check("async_rst_countB", int'(bus.countB), 0);
`endif
        bus.senseA_raw = 1'b0;
        bus.senseB_raw = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(3);

        check("pending_carA_edges", qa.size(), 0);
        check("pending_carB_edges", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
